// File: rtl/sar_logic_param.sv
// Successive-approximation register control: resolves an N-bit code MSB-first from Op/Om.
// Optional sample phase (smpl port, SAMPLE state) enabled by defining SAR_SAMPLE_EN.
module sar_logic_param #(
    parameter int unsigned N        = 8,
    parameter int unsigned TIMEOUT  = 4,
    parameter int unsigned SMPL_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    input  logic         Op,
    input  logic         Om,
    output logic [N-1:0] B,
    output logic [N-1:0] BN,
    output logic [N-1:0] D,
    output logic         rdy,
    output logic         busy,
    output logic         err
`ifdef SAR_SAMPLE_EN
    ,
    output logic         smpl
`endif
);

    localparam int unsigned   IW        = $clog2(N);
    localparam logic [N-1:0]  MSB       = {1'b1, {(N-1){1'b0}}};
    localparam logic [IW-1:0] I_TOP     = IW'(N - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_TRIAL, S_DONE} state_t;

    state_t state, state_nxt;

`ifdef SAR_SAMPLE_EN
    localparam state_t     S_START   = S_SAMPLE;
    localparam logic [7:0] SMPL_LAST = 8'(SMPL_CYC - 1);
    logic [7:0] scnt;
    logic       smpl_done;
    assign smpl_done = (scnt == SMPL_LAST);
`else
    localparam state_t S_START = S_TRIAL;
    logic smpl_done;
    assign smpl_done = 1'b1;
`endif

    logic [IW-1:0] i;
    logic [7:0]    wait_cnt;
    logic          fin;
    logic          decisive, timeout_hit, advance, bit_val;

    assign decisive    = Op ^ Om;
    assign timeout_hit = !decisive && (wait_cnt == WAIT_LAST);
    assign advance     = decisive || timeout_hit;
    // A timed-out bit always resolves to 0.
    assign bit_val     = decisive & Op;
    assign BN          = ~B;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (En) state_nxt = S_START;
            S_SAMPLE: begin
                if (!En)            state_nxt = S_IDLE;
                else if (smpl_done) state_nxt = S_TRIAL;
            end
            S_TRIAL: begin
                if (!En)     state_nxt = S_IDLE;
                else if (fin) state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = En ? S_START : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SAMPLE) || (state == S_TRIAL);
        rdy  = (state == S_DONE);
`ifdef SAR_SAMPLE_EN
        smpl = (state == S_SAMPLE);
`endif
    end

    // fin marks "bit 0 resolved": B holds the final code for one cycle before it is captured in D.
    always_ff @(posedge clk) begin
        if (rst) begin
            B        <= '0;
            D        <= '0;
            err      <= 1'b0;
            i        <= '0;
            wait_cnt <= '0;
            fin      <= 1'b0;
`ifdef SAR_SAMPLE_EN
            scnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (En) begin
                        err      <= 1'b0;
                        wait_cnt <= '0;
                        fin      <= 1'b0;
                        i        <= I_TOP;
`ifdef SAR_SAMPLE_EN
                        B        <= '0;
                        scnt     <= '0;
`else
                        B        <= MSB;
`endif
                    end else begin
                        B <= '0;
                    end
                end
`ifdef SAR_SAMPLE_EN
                S_SAMPLE: begin
                    if (!En)            B    <= '0;
                    else if (smpl_done) B    <= MSB;
                    else                scnt <= scnt + 8'd1;
                end
`endif
                S_TRIAL: begin
                    if (!En) begin
                        B   <= '0;
                        fin <= 1'b0;
                    end else if (fin) begin
                        D <= B;
                    end else if (advance) begin
                        B[i]     <= bit_val;
                        wait_cnt <= '0;
                        if (timeout_hit) err <= 1'b1;
                        if (i != '0) begin
                            B[i - 1'b1] <= 1'b1;
                            i           <= i - 1'b1;
                        end else begin
                            fin <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic_param.sv
// Directed bench for sar_logic_param (N=8, TIMEOUT=4); sample-phase checks when SAR_SAMPLE_EN is defined.
module tb_sar_logic_param;

    logic       clk = 1'b0;
    logic       rst, En, Op, Om;
    logic [7:0] B, BN, D;
    logic       rdy, busy, err;
`ifdef SAR_SAMPLE_EN
    logic       smpl;
    localparam int SC = 2;
`else
    localparam int SC = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] alt_b [8] = '{8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hAC, 8'hAA, 8'hAB, 8'hAA};

    sar_logic_param #(.N(8), .TIMEOUT(4), .SMPL_CYC(2)) dut (
        .clk(clk), .rst(rst), .En(En), .Op(Op), .Om(Om),
        .B(B), .BN(BN), .D(D), .rdy(rdy), .busy(busy), .err(err)
`ifdef SAR_SAMPLE_EN
        , .smpl(smpl)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises En and runs through the optional sample phase until the MSB trial is presented.
    task automatic start_conv();
        En = 1'b1;
        for (int k = 0; k < SC; k++) begin
            step();
`ifdef SAR_SAMPLE_EN
            checks++;
            if (smpl !== 1'b1 || B !== 8'h00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sample_phase: smpl=%b B=%h busy=%b, required smpl=1 B=00 busy=1", smpl, B, busy);
            end
`endif
        end
        step();
        checks++;
        if (B !== 8'h80 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_msb: B=%h busy=%b, required B=80 busy=1", B, busy);
        end
`ifdef SAR_SAMPLE_EN
        checks++;
        if (smpl !== 1'b0) begin
            errors++;
            $display("FAIL smpl_low_in_trial: smpl=%b, required 0", smpl);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; En = 1'b0; Op = 1'b0; Om = 1'b0;
        step(); step();
        checks++;
        if (B !== 8'h00 || BN !== 8'hFF || D !== 8'h00 || rdy !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: B=%h BN=%h D=%h rdy=%b busy=%b err=%b, required 00 FF 00 0 0 0",
                     B, BN, D, rdy, busy, err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alternate();
        start_conv();
        for (int k = 0; k < 8; k++) begin
            Op = (k % 2 == 0);
            Om = ~Op;
            step();
            checks++;
            if (B !== alt_b[k] || rdy !== 1'b0) begin
                errors++;
                $display("FAIL alt_step%0d: B=%h rdy=%b, required B=%h rdy=0", k, B, rdy, alt_b[k]);
            end
        end
        step();
        checks++;
        if (rdy !== 1'b1 || D !== 8'hAA || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL alt_done: rdy=%b D=%h err=%b busy=%b, required 1 AA 0 0", rdy, D, err, busy);
        end
        En = 1'b0;
        step();
        checks++;
        if (rdy !== 1'b0 || B !== 8'h00 || D !== 8'hAA) begin
            errors++;
            $display("FAIL alt_idle: rdy=%b B=%h D=%h, required 0 00 AA", rdy, B, D);
        end
    endtask

    task automatic test_abort();
        start_conv();
        for (int k = 0; k < 3; k++) begin
            Op = (k % 2 == 0);
            Om = ~Op;
            step();
            checks++;
            if (B !== alt_b[k]) begin
                errors++;
                $display("FAIL abort_step%0d: B=%h, required %h", k, B, alt_b[k]);
            end
        end
        En = 1'b0;
        step();
        checks++;
        if (B !== 8'h00 || BN !== 8'hFF || busy !== 1'b0 || rdy !== 1'b0 || D !== 8'hAA) begin
            errors++;
            $display("FAIL abort_idle: B=%h BN=%h busy=%b rdy=%b D=%h, required 00 FF 0 0 AA", B, BN, busy, rdy, D);
        end
        step();
        checks++;
        if (rdy !== 1'b0 || D !== 8'hAA) begin
            errors++;
            $display("FAIL abort_no_rdy: rdy=%b D=%h, required 0 AA", rdy, D);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        Op = 1'b0; Om = 1'b0;
        start_conv();
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            n++;
            step();
            if (n == 3) begin
                checks++;
                if (B !== 8'h80 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_wait: B=%h err=%b, required 80 0", B, err);
                end
            end
            if (n == 4) begin
                checks++;
                if (B !== 8'h40 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_first_bit: B=%h err=%b, required 40 1", B, err);
                end
            end
            if (rdy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 33) begin
            errors++;
            $display("FAIL timeout_latency: rdy after %0d edges (seen=%0d), required 33", n, seen);
        end
        checks++;
        if (D !== 8'h00 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: D=%h err=%b, required 00 1", D, err);
        end
        En = 1'b0;
        step();
        checks++;
        if (err !== 1'b1 || B !== 8'h00) begin
            errors++;
            $display("FAIL timeout_err_sticky: err=%b B=%h, required 1 00", err, B);
        end
    endtask

    task automatic test_back_to_back();
        Op = 1'b1; Om = 1'b0;
        start_conv();
        repeat (8) step();
        step();
        checks++;
        if (rdy !== 1'b1 || D !== 8'hFF) begin
            errors++;
            $display("FAIL ones_done: rdy=%b D=%h, required 1 FF", rdy, D);
        end
        step();
        checks++;
        if (rdy !== 1'b0 || busy !== 1'b1 || B !== ((SC > 0) ? 8'h00 : 8'h80) || D !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back: rdy=%b busy=%b B=%h D=%h, required 0 1 %h FF",
                     rdy, busy, B, D, (SC > 0) ? 8'h00 : 8'h80);
        end
        En = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || B !== 8'h00 || D !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_abort: busy=%b B=%h D=%h, required 0 00 FF", busy, B, D);
        end
    endtask

    task automatic test_reset_mid();
        Op = 1'b0; Om = 1'b0;
        start_conv();
        repeat (5) step();
        checks++;
        if (err !== 1'b1 || B !== 8'h40) begin
            errors++;
            $display("FAIL midrst_pre: err=%b B=%h, required 1 40", err, B);
        end
        rst = 1'b1;
        step();
        checks++;
        if (B !== 8'h00 || BN !== 8'hFF || D !== 8'h00 || rdy !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: B=%h BN=%h D=%h rdy=%b busy=%b err=%b, required 00 FF 00 0 0 0",
                     B, BN, D, rdy, busy, err);
        end
        rst = 1'b0;
        start_conv();
        for (int k = 0; k < 8; k++) begin
            Op = (k % 2 == 0);
            Om = ~Op;
            step();
        end
        step();
        checks++;
        if (rdy !== 1'b1 || D !== 8'hAA || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clean: rdy=%b D=%h err=%b, required 1 AA 0", rdy, D, err);
        end
        En = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
